// File: rtl/uart_tx.sv
// UART transmit engine: pops one byte per frame from the TX FIFO and shifts it out LSB first (8N1/8N2).
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits (even, or odd when PARITY_ODD=1).
module uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned CNT_W = clog2_f(CLKS_PER_BIT);
  localparam int unsigned IDX_W = clog2_f(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX      = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_IDX_MAX = IDX_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_INV = 1'(PARITY_ODD);
  logic parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_MAX);

  // Next-state, baud counter and line value; idx_q doubles as the stop-bit index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (enable && !fifo_empty) state_d = S_POP;
      end
      S_POP: state_d = S_LATCH;
      S_LATCH: begin
        shift_d = fifo_dout;
        tx_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_START;
`ifdef UART_TX_PARITY_EN
        parity_d = (^fifo_dout) ^ PAR_INV;
`endif
      end
      S_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_MAX) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        tx_d  = 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STOP_IDX_MAX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    busy_d  = (state_d != S_IDLE);
    rd_en_d = (state_d == S_POP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO model, table of known frames, corner sequences and random bytes.
module tb_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned NSTOP = 1;
  localparam int unsigned PODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NPAR = 1;
`else
  localparam int unsigned NPAR = 0;
`endif
  localparam int unsigned NBITS = 1 + DW + NPAR + NSTOP;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_dout = '0;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int underflow = 0;
  int n_vec = 0;
  int n_err = 0;

  uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (NSTOP),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  // Registered-read FIFO: data appears the cycle after the pop edge.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      pops <= pops + 1;
      if (wr_ptr == rd_ptr) underflow <= underflow + 1;
      else begin
        fifo_dout <= mem[rd_ptr[7:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line sequence in time order: start, data LSB first, optional parity, stop bits.
  function automatic logic [15:0] model_line(input logic [7:0] d);
    logic [15:0] l;
    l = '1;
    l[0] = 1'b0;
    for (int i = 0; i < int'(DW); i++) l[4'(i + 1)] = d[3'(i)];
    if (NPAR == 1) l[4'(DW + 1)] = (^d) ^ 1'(PODD);
    return l;
  endfunction

  task automatic wait_pop(input int max_cyc, output int waited);
    waited = 0;
    while (waited < max_cyc) begin
      @(negedge clk);
      waited++;
      if (fifo_rd_en === 1'b1) return;
      chk("mark_before_pop", 32'(tx), 32'd1);
    end
    chk("pop_timeout", 32'd0, 32'd1);
    waited = -1;
  endtask

  // Called on the pop sample; checks every cycle up to and including the tx_done pulse.
  task automatic check_frame(input logic [15:0] line, input string name, input int drop_bit);
    @(negedge clk);
    chk({name, " latch"}, 32'({tx, busy, tx_done, fifo_rd_en}), 32'(4'b1100));
    for (int b = 0; b < int'(NBITS); b++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        @(negedge clk);
        if (b == drop_bit && c == 1) enable = 1'b0;
        chk($sformatf("%s bit%0d", name, b), 32'({tx, busy, tx_done, fifo_rd_en}),
            32'({line[4'(b)], 3'b100}));
      end
    end
    @(negedge clk);
    chk({name, " done"}, 32'({tx, busy, tx_done, fifo_rd_en}), 32'(4'b1010));
  endtask

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] line;
  } vec_t;

  vec_t       tbl [5];
  int         w;
  int         p0;
  int         nb;
  logic [7:0] bytes [3];

  initial begin
`ifdef UART_TX_PARITY_EN
    tbl[0] = '{8'hA5, 16'h054A};
    tbl[1] = '{8'h00, 16'h0400};
    tbl[2] = '{8'hFF, 16'h05FE};
    tbl[3] = '{8'h3C, 16'h0478};
    tbl[4] = '{8'h07, 16'h060E};
`else
    tbl[0] = '{8'hA5, 16'h034A};
    tbl[1] = '{8'h00, 16'h0200};
    tbl[2] = '{8'hFF, 16'h03FE};
    tbl[3] = '{8'h3C, 16'h0278};
    tbl[4] = '{8'h07, 16'h020E};
`endif
    rst_n  = 1'b1;
    enable = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({tx, busy, tx_done, fifo_rd_en}), 32'(4'b1000));
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("idle_empty", 32'({tx, busy, tx_done, fifo_rd_en}), 32'(4'b1000));
    end
    rst_n = 1'b0;
    #1 chk("reset_mid_idle", 32'({tx, busy, tx_done, fifo_rd_en}), 32'(4'b1000));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      push(tbl[i].data);
      wait_pop(4, w);
      if (w > 0) begin
        chk($sformatf("tbl%0d pop_latency", i), 32'(w), 32'd1);
        check_frame(tbl[i].line, $sformatf("tbl%0d", i), -1);
      end
    end

    // Back-to-back frames: next pop one sample after tx_done gives 3 mark cycles.
    p0 = pops;
    push(8'h00);
    push(8'hFF);
    wait_pop(4, w);
    if (w > 0) check_frame(model_line(8'h00), "b2b_first", -1);
    wait_pop(4, w);
    chk("b2b_gap", 32'(w), 32'd1);
    if (w > 0) check_frame(model_line(8'hFF), "b2b_second", -1);
    repeat (10) @(negedge clk);
    chk("b2b_pop_count", 32'(pops - p0), 32'd2);

    // Held off by enable, then enable dropped during data bit 3.
    enable = 1'b0;
    p0 = pops;
    push(8'h5A);
    push(8'h77);
    repeat (100) begin
      @(negedge clk);
      chk("disabled_idle", 32'({tx, busy, fifo_rd_en}), 32'(3'b100));
    end
    enable = 1'b1;
    wait_pop(4, w);
    if (w > 0) check_frame(model_line(8'h5A), "drop_en", 4);
    repeat (30) begin
      @(negedge clk);
      chk("after_drop", 32'({tx, busy, fifo_rd_en}), 32'(3'b100));
    end
    chk("drop_pop_count", 32'(pops - p0), 32'd1);
    enable = 1'b1;
    wait_pop(4, w);
    if (w > 0) check_frame(model_line(8'h77), "resume", -1);

    // Reset in the middle of data bit 5 of 0x3C; the next byte must go out intact.
    push(8'h3C);
    push(8'h66);
    wait_pop(4, w);
    if (w > 0) begin
      repeat (27) @(negedge clk);
      chk("pre_reset", 32'({tx, busy}), 32'(2'b11));
      rst_n = 1'b0;
      #1 chk("abort_reset", 32'({tx, busy, tx_done, fifo_rd_en}), 32'(4'b1000));
      @(negedge clk);
      rst_n = 1'b1;
      wait_pop(6, w);
      if (w > 0) check_frame(model_line(8'h66), "post_reset", -1);
    end

    // Random batches of 1..3 bytes after random idle gaps.
    for (int r = 0; r < 8; r++) begin
      enable = 1'b0;
      nb = int'($urandom_range(1, 3));
      for (int k = 0; k < nb; k++) begin
        bytes[k] = 8'($urandom);
        push(bytes[k]);
      end
      repeat ($urandom_range(0, 5)) begin
        @(negedge clk);
        chk("rand_gap", 32'({tx, fifo_rd_en}), 32'(2'b10));
      end
      enable = 1'b1;
      for (int k = 0; k < nb; k++) begin
        wait_pop(4, w);
        if (w > 0) begin
          chk($sformatf("rand%0d_%0d latency", r, k), 32'(w), 32'd1);
          check_frame(model_line(bytes[k]), $sformatf("rand%0d_%0d 0x%02h", r, k, bytes[k]), -1);
        end
      end
    end

    repeat (5) @(negedge clk);
    chk("fifo_underflow", 32'(underflow), 32'd0);
    chk("fifo_drained", 32'(wr_ptr - rd_ptr), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog timeout");
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmit engine; the reader on the read side of the UART's byte FIFO.
- Pops one byte at a time from the TX FIFO, serialises it as 8N1 or 8N2, LSB first, and drives the tx pin.
- Sits between the TX FIFO read port and the top-level tx pad.

Parameters:
- DATA_WIDTH, 8, bits per character; must match the FIFO data width.
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Legal range ≥2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  reset: asynchronous, active-low.
- enable  in  1  allow new frames to start; sampled only in IDLE.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_WIDTH  FIFO read data; registered in the FIFO, valid the cycle after the pop edge.
- fifo_rd_en  out  1  FIFO pop strobe; high for exactly one cycle per byte.
- tx  out  1  serial line; idle/mark = 1.
- busy  out  1  high whenever state != IDLE.
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (async) values:
  - tx=1, busy=0, fifo_rd_en=0, tx_done=0.
  - state=IDLE; baud counter, bit index and shift register all 0.
- States: IDLE, POP, LATCH, START, DATA, [PARITY], STOP.
- IDLE: on the edge E0 where enable=1 and fifo_empty=0, go to POP. Otherwise stay; tx=1.
- POP: lasts one cycle; fifo_rd_en=1 (decoded from state). At edge E1 the FIFO advances; go to LATCH.
- LATCH: lasts one cycle; fifo_dout is valid. At edge E2, load the shift register, set tx=0, clear the baud counter, go to START.
  - tx falls exactly 2 edges after E0.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0 and tx=shift[0].
- DATA: each bit held CLKS_PER_BIT cycles, LSB first.
  - After bit DATA_WIDTH-1, go to PARITY if compiled in, else to STOP with tx=1.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final edge: tx_done=1 for one cycle, return to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; width = ceil(log2(CLKS_PER_BIT)), computed by a constant log2 function.
  - Bit advance happens at count == CLKS_PER_BIT-1.
  - Stop duration uses an extra stop-bit index for STOP_BITS=2.
- Back-to-back frames: with the FIFO non-empty and enable held high, the mark time between the end of the stop bit(s) and the next start bit is exactly 3 extra clk cycles (IDLE, POP, LATCH).
- Popping rules:
  - fifo_rd_en is never asserted unless fifo_empty=0 was sampled in IDLE.
  - It is never asserted outside POP.
  - Each pop yields exactly one frame.
- enable deasserted mid-frame: the current frame completes unchanged; no further pop.
- Async reset mid-frame: tx returns to 1 immediately and the frame is aborted. A byte already popped is lost (accepted behaviour).
- No combinational path from any input to tx.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA and lasts CLKS_PER_BIT cycles.
  - tx = XOR of the data bits (even parity), inverted when PARITY_ODD=1.
  - Frame length grows by one bit.
- Undefined:
  - No PARITY state and no parity logic.
  - PARITY_ODD is ignored.
  - Frame = start + DATA_WIDTH + stop bit(s).

Test Plan (CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1 unless stated):
1. Reset: assert rst_n=0 mid-idle -> tx=1, busy=0, fifo_rd_en=0, tx_done=0; all remain so with fifo_empty=1, enable=1.
2. Single byte 0xA5 -> fifo_rd_en high 1 cycle; tx falls 2 edges after the pop decision; line reads 0 then 1,0,1,0,0,1,0,1, then 1, each for 4 cycles (40 cycles total); tx_done pulses once at frame end; busy low afterwards.
3. Back-to-back 0x00 then 0xFF -> exactly two fifo_rd_en pulses; exactly 3 extra mark cycles between first stop-bit end and second start bit; second frame has 8 data bits of 1.
4. enable=0 with FIFO non-empty -> no pop, tx=1 for 100 cycles. Then enable=1, and drop enable during bit 3 -> that frame completes and no second pop occurs.
5. rst_n pulsed low during data bit 5 of 0x3C -> tx=1 and busy=0 immediately. After release with enable=1 and FIFO non-empty, the next byte is sent as a correct full frame.
6. UART_TX_PARITY_EN defined, PARITY_ODD=0, byte 0x07 -> parity bit 1 after D7; frame 44 cycles. With PARITY_ODD=1 -> parity bit 0. With STOP_BITS=2 -> stop high for 8 cycles before tx_done.
